retire_tracker: RTL and testbench
=================================

Name: retire_tracker

Overview:
- Back end of the 8-slot instruction window; the dispatcher is the front end.
- Holds per-slot valid/complete state and frees completed slots in program order, up to RETIRE_MAX per cycle.
- Produces `possible_remain_valid` and `jump_triggering_now` for the dispatcher.
- Consumes the dispatcher's slot-entry mask and age matrix.
- Kills wrong-path slots on a branch mispredict, then holds a fixed-length redirect window.

Parameters:
- RETIRE_MAX, 4: maximum slots freed per cycle (1..8).
- FLUSH_CYCLES, 2: cycles `jump_triggering_now` stays high after a mispredict (>=1).

Ports:
- main_clk  in  1  clock, all state on rising edge.
- main_rst  in  1  asynchronous active-high reset.
- is_new_instruction_entering_this_cycle  in  8  per-slot entry mask from the dispatcher.
- isAfter  in  8x8  age matrix. [i][j]=1 means slot i is younger than slot j. Meaningful only between valid slots.
- done_pulse  in  8  execution-complete pulse per slot.
- br_valid  in  1  branch resolution strobe.
- br_slot  in  3  slot of the resolving branch.
- br_mispredict  in  1  qualifies br_valid.
- possible_remain_valid  out  8  slots still occupied next cycle (combinational).
- retire_mask  out  8  slots freed this cycle (combinational).
- jump_triggering_now  out  1  redirect/flush in progress.
- retired_total  out  32  registered count of retired instructions.
- slot_valid_q  out  8  registered occupancy (debug/verify).

Behaviour:

Reset (async, main_rst=1):
- slot_valid=0, slot_done=0, retired_total=0, FSM=RUN, flush counter=0.
- Outputs while in reset: possible_remain_valid=00, retire_mask=00, jump_triggering_now=0.

Completion:
- slot_done[i] sets at the edge after done_pulse[i] when slot_valid[i]=1.
- done_pulse on an invalid slot is ignored.
- A slot entering clears slot_done[i] and sets slot_valid[i]. Entry wins over done_pulse in the same cycle.
- Earliest retire is the cycle after the done_pulse edge (latency 1).

Retire eligibility (combinational): slot i may retire when all hold:
- slot_valid[i] & slot_done[i];
- every valid j with isAfter[i][j]=1 is also done;
- older_count(i) < RETIRE_MAX, where older_count(i) = popcount of valid j with isAfter[i][j].
- retire_mask = eligible & ~kill_mask.

Kill:
- kill_mask = valid slots younger than br_slot.
- Active only when br_valid & br_mispredict, slot_valid[br_slot]=1, and br_slot is not itself in this cycle's kill_mask. Otherwise kill_mask=0 and the strobe is ignored.
- The branch slot is never killed.

Occupancy:
- possible_remain_valid = slot_valid & ~retire_mask & ~kill_mask.
- Next slot_valid = possible_remain_valid | is_new_instruction_entering_this_cycle.
- Entry into a slot with possible_remain_valid=1 is a protocol violation; the bench asserts it never occurs.

Counter:
- retired_total += popcount(retire_mask) each cycle.
- Wraps modulo 2^32.

FSM:
- RUN: jump_triggering_now=0.
- Accepted mispredict: jump_triggering_now=1 combinationally in the same cycle, counter loads FLUSH_CYCLES-1, next state DRAIN (or RUN if FLUSH_CYCLES=1).
- DRAIN: jump_triggering_now=1; counter decrements; returns to RUN when the counter is 0.
- An accepted mispredict in DRAIN performs a new kill and reloads the counter.
- Retirement continues in every state.

Reset mid-operation: all state clears immediately; nothing retires on the reset edge.

Test Plan:
1. Reset, then enter slots 0,1,2 in that age order; done_pulse=0b110 -> no retire (slot 0 not done). Then done_pulse=0b001 -> next cycle retire_mask=0b111, retired_total=3, possible_remain_valid=0.
2. Eight valid slots with ages 0..7, all done in the same cycle, RETIRE_MAX=4 -> retire_mask=0x0F, then 0xF0; retired_total=8 after two cycles.
3. Valid slots 0..5 with ages 0..5; br_valid=1, br_mispredict=1, br_slot=2 -> in the same cycle possible_remain_valid=0x07 and jump_triggering_now=1 for exactly 2 cycles.
4. Mispredict in DRAIN on br_slot=1 (valid) -> slot 2 killed, counter reloaded, jump_triggering_now high 2 more cycles. Mispredict on an invalid slot -> ignored.
5. done_pulse to a slot in the same cycle it enters -> slot_done stays 0 and the slot does not retire.
6. main_rst asserted mid-DRAIN with 5 valid slots -> slot_valid_q=0, jump_triggering_now=0, retired_total=0 without waiting for a clock edge.

Source files
------------

// File: rtl/retire_tracker_if.sv
// Dispatcher <-> retire tracker connection for the 8-slot instruction window.
// The dispatcher side (master) drives slot entry, age, completion and branch
// resolution. The tracker side (slave) returns occupancy, retirement and redirect status.
interface retire_tracker_if;
    logic [7:0]      is_new_instruction_entering_this_cycle;
    logic [7:0][7:0] isAfter;          // [i][j]=1: slot i is younger than slot j
    logic [7:0]      done_pulse;
    logic            br_valid;
    logic [2:0]      br_slot;
    logic            br_mispredict;
    logic [7:0]      possible_remain_valid;
    logic [7:0]      retire_mask;
    logic            jump_triggering_now;
    logic [31:0]     retired_total;
    logic [7:0]      slot_valid_q;

    modport master (
        output is_new_instruction_entering_this_cycle, isAfter, done_pulse,
               br_valid, br_slot, br_mispredict,
        input  possible_remain_valid, retire_mask, jump_triggering_now,
               retired_total, slot_valid_q
    );

    modport slave (
        input  is_new_instruction_entering_this_cycle, isAfter, done_pulse,
               br_valid, br_slot, br_mispredict,
        output possible_remain_valid, retire_mask, jump_triggering_now,
               retired_total, slot_valid_q
    );
endinterface

// File: rtl/retire_tracker.sv
// Back end of the 8-slot instruction window. It tracks per-slot valid/done state,
// frees completed slots in program order (at most RETIRE_MAX per cycle), kills
// wrong-path slots on a mispredict and holds a fixed-length redirect window.
module retire_tracker #(
    parameter int RETIRE_MAX   = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic             main_clk,
    input  logic             main_rst,
    retire_tracker_if.slave  bus
);
    typedef enum logic {RUN, DRAIN} state_t;

    localparam int             CW     = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CW-1:0]  RELOAD = CW'(FLUSH_CYCLES - 1);
    localparam logic [3:0]     RMAX   = 4'(RETIRE_MAX);

    logic [7:0]      slot_valid;
    logic [7:0]      slot_done;
    logic [31:0]     retired_total;
    state_t          state;
    logic [CW-1:0]   flush_cnt;

    logic [7:0][3:0] older_cnt;
    logic [7:0]      blocked;
    logic [7:0]      eligible;
    logic [7:0]      kill_raw;
    logic [7:0]      kill_mask;
    logic            kill_accept;
    logic [7:0]      retire_mask;
    logic [7:0]      remain;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int k = 0; k < 8; k++) n = n + {3'b0, v[k]};
        return n;
    endfunction

    // Count valid older slots per slot and flag any older slot that is not yet done.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        older_cnt = '0;
        blocked   = '0;
        eligible  = '0;
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                if (j != i && slot_valid[j] && bus.isAfter[i][j]) begin
                    older_cnt[i] = older_cnt[i] + 4'd1;
                    if (!slot_done[j]) blocked[i] = 1'b1;
                end
            end
            eligible[i] = slot_valid[i] & slot_done[i] & ~blocked[i] & (older_cnt[i] < RMAX);
        end
    end

    // Decide whether a mispredict is accepted and which younger slots it removes.
    always_comb begin
        kill_raw = '0;
        for (int j = 0; j < 8; j++) begin
            kill_raw[j] = slot_valid[j] & bus.isAfter[j][bus.br_slot];
        end
        // A branch that would land in its own kill set is not accepted, so it is never killed.
        kill_accept = bus.br_valid & bus.br_mispredict
                    & slot_valid[bus.br_slot] & ~kill_raw[bus.br_slot];
        kill_mask   = kill_accept ? kill_raw : 8'h00;
    end

    assign retire_mask = eligible & ~kill_mask;
    assign remain      = slot_valid & ~retire_mask & ~kill_mask;

    assign bus.retire_mask           = retire_mask;
    assign bus.possible_remain_valid = remain;
    assign bus.jump_triggering_now   = (state == DRAIN) | kill_accept;
    assign bus.retired_total         = retired_total;
    assign bus.slot_valid_q          = slot_valid;

    // Slot occupancy and completion. Entry clears the done bit and beats a same-cycle done pulse.
    always_ff @(posedge main_clk or posedge main_rst) begin
        if (main_rst) begin
            slot_valid <= '0;
            slot_done  <= '0;
        end else begin
            // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
            slot_valid <= remain | bus.is_new_instruction_entering_this_cycle;
            for (int i = 0; i < 8; i++) begin
                if (bus.is_new_instruction_entering_this_cycle[i])
                    slot_done[i] <= 1'b0;
                else
                    slot_done[i] <= remain[i] & (slot_done[i] | bus.done_pulse[i]);
            end
        end
    end

    // Running count of retired instructions, wrapping modulo 2^32.
    always_ff @(posedge main_clk or posedge main_rst) begin
        if (main_rst) retired_total <= '0;
        else          retired_total <= retired_total + {28'b0, popcount8(retire_mask)};
    end

    // Redirect window: an accepted mispredict opens or reloads the window, DRAIN counts it down.
    always_ff @(posedge main_clk or posedge main_rst) begin
        if (main_rst) begin
            state     <= RUN;
            flush_cnt <= '0;
        end else if (kill_accept) begin
            if (FLUSH_CYCLES > 1) begin
                state     <= DRAIN;
                flush_cnt <= RELOAD;
            end else begin
                state     <= RUN;
                flush_cnt <= '0;
            end
        end else if (state == DRAIN) begin
            if (flush_cnt == CW'(1) || flush_cnt == '0) begin
                state     <= RUN;
                flush_cnt <= '0;
            end else begin
                flush_cnt <= flush_cnt - CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_retire_tracker.sv
// Directed bench for retire_tracker: in-order retirement, the retire-width limit,
// mispredict kill and redirect window, entry/done collision, and mid-run reset.
module tb_retire_tracker;
    logic main_clk = 1'b0;
    logic main_rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    retire_tracker_if bus ();

    retire_tracker #(.RETIRE_MAX(4), .FLUSH_CYCLES(2)) dut (
        .main_clk (main_clk),
        .main_rst (main_rst),
        .bus      (bus)
    );

    always #5 main_clk = ~main_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge main_clk);
        #1;
    endtask

    task automatic idle();
        bus.is_new_instruction_entering_this_cycle = 8'h00;
        bus.done_pulse    = 8'h00;
        bus.br_valid      = 1'b0;
        bus.br_mispredict = 1'b0;
        bus.br_slot       = 3'd0;
    endtask

    // Entering a slot that is still occupied is a dispatcher protocol violation.
    always @(negedge main_clk) begin
        if (!main_rst) begin
            total++;
            assert (!(|(bus.is_new_instruction_entering_this_cycle & bus.possible_remain_valid))) else begin
                bad++;
                $error("FAIL entry_into_occupied observed=%0h expected=0",
                       bus.is_new_instruction_entering_this_cycle & bus.possible_remain_valid);
            end
        end
    end

    initial begin
        idle();
        // Age order equals slot index: lower slot is older.
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                bus.isAfter[i][j] = (i > j);

        // Reset state
        #2;
        check("rst_prv",    32'(bus.possible_remain_valid), 32'h00);
        check("rst_retire", 32'(bus.retire_mask),           32'h00);
        check("rst_jump",   32'(bus.jump_triggering_now),   32'h0);
        check("rst_valid",  32'(bus.slot_valid_q),          32'h00);
        check("rst_total",  bus.retired_total,              32'h0);
        repeat (2) @(posedge main_clk);
        @(negedge main_clk) main_rst = 1'b0;
        tick();

        // 1: in-order retirement waits for the oldest slot
        bus.is_new_instruction_entering_this_cycle = 8'h07;
        tick();
        idle();
        check("t1_valid", 32'(bus.slot_valid_q), 32'h07);
        bus.done_pulse = 8'h06;
        #1 check("t1_retire_a", 32'(bus.retire_mask), 32'h00);
        tick();
        idle();
        check("t1_retire_b", 32'(bus.retire_mask), 32'h00);
        bus.done_pulse = 8'h01;
        #1 check("t1_retire_c", 32'(bus.retire_mask), 32'h00);
        tick();
        idle();
        check("t1_retire_d", 32'(bus.retire_mask),           32'h07);
        check("t1_prv",      32'(bus.possible_remain_valid), 32'h00);
        tick();
        check("t1_total", bus.retired_total,      32'd3);
        check("t1_empty", 32'(bus.slot_valid_q),  32'h00);

        // Mid-run reset between tests
        @(negedge main_clk) main_rst = 1'b1;
        #1;
        check("rst2_total", bus.retired_total, 32'd0);
        @(negedge main_clk) main_rst = 1'b0;
        tick();

        // 2: eight done slots retire in two groups of four
        bus.is_new_instruction_entering_this_cycle = 8'hFF;
        tick();
        idle();
        bus.done_pulse = 8'hFF;
        tick();
        idle();
        check("t2_retire_a", 32'(bus.retire_mask),           32'h0F);
        check("t2_prv_a",    32'(bus.possible_remain_valid), 32'hF0);
        tick();
        check("t2_retire_b", 32'(bus.retire_mask), 32'hF0);
        tick();
        check("t2_total",    bus.retired_total,    32'd8);
        check("t2_retire_c", 32'(bus.retire_mask), 32'h00);

        // 3: mispredict on slot 2 kills 3..5 and raises the redirect for two cycles
        bus.is_new_instruction_entering_this_cycle = 8'h3F;
        tick();
        idle();
        check("t3_jump_pre", 32'(bus.jump_triggering_now), 32'h0);
        bus.br_valid = 1'b1; bus.br_mispredict = 1'b1; bus.br_slot = 3'd2;
        #1;
        check("t3_prv",    32'(bus.possible_remain_valid), 32'h07);
        check("t3_jump_1", 32'(bus.jump_triggering_now),   32'h1);
        tick();
        idle();
        check("t3_jump_2", 32'(bus.jump_triggering_now), 32'h1);
        check("t3_valid",  32'(bus.slot_valid_q),        32'h07);
        tick();
        check("t3_jump_3", 32'(bus.jump_triggering_now), 32'h0);

        // 4: a second mispredict during DRAIN kills again and reloads the window
        bus.br_valid = 1'b1; bus.br_mispredict = 1'b1; bus.br_slot = 3'd2;
        tick();
        idle();
        check("t4_drain", 32'(bus.jump_triggering_now), 32'h1);
        bus.br_valid = 1'b1; bus.br_mispredict = 1'b1; bus.br_slot = 3'd1;
        #1 check("t4_prv", 32'(bus.possible_remain_valid), 32'h03);
        tick();
        idle();
        check("t4_reload", 32'(bus.jump_triggering_now), 32'h1);
        check("t4_valid",  32'(bus.slot_valid_q),        32'h03);
        tick();
        check("t4_run", 32'(bus.jump_triggering_now), 32'h0);
        bus.br_valid = 1'b1; bus.br_mispredict = 1'b1; bus.br_slot = 3'd5;
        #1;
        check("t4_inv_jump", 32'(bus.jump_triggering_now),   32'h0);
        check("t4_inv_prv",  32'(bus.possible_remain_valid), 32'h03);
        bus.br_slot = 3'd0; bus.br_mispredict = 1'b0;
        #1 check("t4_nomisp_prv", 32'(bus.possible_remain_valid), 32'h03);
        tick();
        idle();
        check("t4_inv_after", 32'(bus.jump_triggering_now), 32'h0);
        check("t4_valid_b",   32'(bus.slot_valid_q),        32'h03);

        // 5: done pulse on the entry cycle is ignored
        bus.is_new_instruction_entering_this_cycle = 8'h04;
        bus.done_pulse = 8'h07;
        tick();
        idle();
        check("t5_valid",  32'(bus.slot_valid_q), 32'h07);
        check("t5_retire", 32'(bus.retire_mask),  32'h03);
        tick();
        check("t5_total",   bus.retired_total,    32'd10);
        check("t5_left",    32'(bus.slot_valid_q), 32'h04);
        check("t5_noretire", 32'(bus.retire_mask), 32'h00);
        bus.done_pulse = 8'h04;
        tick();
        idle();
        check("t5_retire_b", 32'(bus.retire_mask), 32'h04);
        tick();
        check("t5_total_b", bus.retired_total,     32'd11);
        check("t5_empty",   32'(bus.slot_valid_q), 32'h00);

        // 6: asynchronous reset in the middle of DRAIN
        bus.is_new_instruction_entering_this_cycle = 8'h1F;
        tick();
        idle();
        bus.br_valid = 1'b1; bus.br_mispredict = 1'b1; bus.br_slot = 3'd4;
        tick();
        idle();
        check("t6_drain", 32'(bus.jump_triggering_now), 32'h1);
        check("t6_valid", 32'(bus.slot_valid_q),        32'h1F);
        main_rst = 1'b1;
        #1;
        check("t6_rst_valid", 32'(bus.slot_valid_q),        32'h00);
        check("t6_rst_jump",  32'(bus.jump_triggering_now), 32'h0);
        check("t6_rst_total", bus.retired_total,            32'd0);
        check("t6_rst_prv",   32'(bus.possible_remain_valid), 32'h00);
        tick();
        check("t6_rst_edge_total", bus.retired_total, 32'd0);
        @(negedge main_clk) main_rst = 1'b0;
        tick();
        check("t6_post_valid", 32'(bus.slot_valid_q), 32'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
